arm_link_scheduler: RTL

- Owns the 5-bit GPIO command link to the Arduino arm controller.
- Arbitrates one-hot arm commands from two requesters: the auto tracking FSM and a manual override from the board switches/keys.
- Sequences each granted command as setup → strobe → gap, using programmable cycle counts.
- Replaces fixed-priority, free-running timing with a req/ack handshake and one-shot fairness.

---
 rtl/arm_link_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/arm_link_scheduler.sv
// Purpose : arbitrates auto/manual one-hot arm commands onto the 5-bit GPIO link (setup, strobe, gap).
// Latency : grant edge -> ack and command bits next cycle; strobe rises SETUP_CYCLES after the command bits.
// Backpr. : requesters hold req until their ack; no request is acked while the link is busy.
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   auto_req / auto_cmd      auto tracking requester, one-hot command
//   manual_req / manual_cmd  switch/key override requester, one-hot command
//   auto_ack / manual_ack    one-cycle pulse: request consumed
//   cmd_err                  one-cycle pulse with an ack: command was not one-hot and was dropped
//   busy                     high whenever the sequencer is not IDLE
//   sig_out                  [4:1] command bits, [0] strobe
module arm_link_scheduler #(
   parameter int unsigned SETUP_CYCLES = 25000000,
   parameter int unsigned HOLD_CYCLES  = 25000000,
   parameter int unsigned GAP_CYCLES   = 5000000,
   parameter int unsigned CNT_W        = 27
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       auto_req,
   input  logic [3:0] auto_cmd,
   input  logic       manual_req,
   input  logic [3:0] manual_cmd,
   output logic       auto_ack,
   output logic       manual_ack,
   output logic       cmd_err,
   output logic       busy,
   output logic [4:0] sig_out
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       sig_d;
   logic             auto_ack_d, manual_ack_d, cmd_err_d, busy_d;
   logic             fair_auto_q, fair_auto_d;
   logic             pick_manual;
   logic [3:0]       cmd_sel;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sig_out     <= 5'b00100;
         auto_ack    <= 1'b0;
         manual_ack  <= 1'b0;
         cmd_err     <= 1'b0;
         busy        <= 1'b0;
         fair_auto_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sig_out     <= sig_d;
         auto_ack    <= auto_ack_d;
         manual_ack  <= manual_ack_d;
         cmd_err     <= cmd_err_d;
         busy        <= busy_d;
         fair_auto_q <= fair_auto_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sig_d        = sig_out;
      auto_ack_d   = 1'b0;
      manual_ack_d = 1'b0;
      cmd_err_d    = 1'b0;
      fair_auto_d  = fair_auto_q;
      pick_manual  = manual_req && !(fair_auto_q && auto_req);
      cmd_sel      = pick_manual ? manual_cmd : auto_cmd;

      case (state_q)
         IDLE: begin
            // While an ack is on the wire the requester has not yet had a
            // chance to drop req; after a dropped (invalid) command we are
            // still IDLE here, so skip arbitration to avoid a double ack.
            if (!auto_ack && !manual_ack && (auto_req || manual_req)) begin
               if (pick_manual) begin
                  manual_ack_d = 1'b1;
                  if (auto_req) fair_auto_d = 1'b1;
               end else begin
                  auto_ack_d  = 1'b1;
                  fair_auto_d = 1'b0;
               end
               if ($onehot(cmd_sel)) begin
                  sig_d   = {cmd_sel, 1'b0};
                  cnt_d   = SETUP_LD;
                  state_d = SETUP;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               sig_d[0] = 1'b1;
               cnt_d    = HOLD_LD;
               state_d  = STROBE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               sig_d[0] = 1'b0;
               cnt_d    = GAP_LD;
               state_d  = GAP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule
